// File: rtl/logic8_uart_tx.sv
// 8N1 UART transmitter that dumps the logic8 A and B registers as two
// back-to-back bytes (A first, LSB first) on a single serial line.
module logic8_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] A_In,
  input  logic [7:0] B_In,
  output logic       Tx,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        byte_idx_q, byte_idx_d;
  logic [7:0]  shifter_q, shifter_d;
  logic [7:0]  snap_b_q, snap_b_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_end;

  assign bit_end = (baud_q == LAST_CLK);

  // Outputs are computed one cycle ahead so Tx/Busy/Done come straight from flops.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + 16'd1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shifter_d  = shifter_q;
    snap_b_d   = snap_b_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        if (Start) begin
          // The A snapshot lives in the shifter; only B needs its own register.
          state_d    = START;
          shifter_d  = A_In;
          snap_b_d   = B_In;
          byte_idx_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          baud_d    = 16'd0;
          bit_idx_d = 3'd0;
          tx_d      = shifter_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shifter_d = shifter_q >> 1;
            tx_d      = shifter_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = 16'd0;
          if (!byte_idx_q) begin
            state_d    = START;
            byte_idx_d = 1'b1;
            shifter_d  = snap_b_q;
            tx_d       = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      baud_q     <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 1'b0;
      shifter_q  <= 8'd0;
      snap_b_q   <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shifter_q  <= shifter_d;
      snap_b_q   <= snap_b_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_logic8_uart_tx.sv
// Self-checking bench for logic8_uart_tx: random A/B dumps compared against a
// frame model built from the 8N1 rules, plus lockout, hold and reset scenarios.
module tb_logic8_uart_tx;

  localparam int N     = 4;
  localparam int FRAME = 20 * N;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] A_In;
  logic [7:0] B_In;
  logic       Tx;
  logic       Busy;
  logic       Done;

  int checks   = 0;
  int failures = 0;
  logic tx_log [FRAME];

  logic8_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .A_In  (A_In),
    .B_In  (B_In),
    .Tx    (Tx),
    .Busy  (Busy),
    .Done  (Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Line level t cycles after acceptance: symbol = t/N, byte = symbol/10,
  // position 0 is the start bit, 9 the stop bit, 1..8 data LSB first.
  function automatic logic model_tx(input logic [7:0] a, input logic [7:0] b, input int t);
    int sym = t / N;
    int pos = sym % 10;
    logic [7:0] d = (sym < 10) ? a : b;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return d[pos-1];
  endfunction

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      checks++;
      if (Tx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
        failures++;
        $display("FAIL %s cyc=%0d: got Tx=%b Busy=%b Done=%b, want Tx=1 Busy=0 Done=0",
                 name, i, Tx, Busy, Done);
      end
      tick();
    end
  endtask

  // Accepts one dump and checks every cycle of it plus the Done cycle after.
  task automatic expect_frame(input logic [7:0] a, input logic [7:0] b,
                              input int change_at, input logic [7:0] chg,
                              input int pulse_at, input string name);
    A_In = a; B_In = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int t = 0; t < FRAME; t++) begin
      logic exp_tx = model_tx(a, b, t);
      tx_log[t] = Tx;
      checks++;
      if (Tx !== exp_tx || Busy !== 1'b1 || Done !== 1'b0) begin
        failures++;
        $display("FAIL %s t=%0d: got Tx=%b Busy=%b Done=%b, want Tx=%b Busy=1 Done=0",
                 name, t, Tx, Busy, Done, exp_tx);
      end
      if (t == change_at) begin A_In = chg; B_In = chg; end
      if (t == pulse_at) Start = 1'b1;
      tick();
      Start = 1'b0;
    end
    checks++;
    if (Tx !== 1'b1 || Busy !== 1'b0 || Done !== 1'b1) begin
      failures++;
      $display("FAIL %s done: got Tx=%b Busy=%b Done=%b, want Tx=1 Busy=0 Done=1",
               name, Tx, Busy, Done);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse_width: got Done=%b Busy=%b, want Done=0 Busy=0",
               name, Done, Busy);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; A_In = 8'h00; B_In = 8'h00;
    tick(); tick();
    Reset = 1'b0;
    check_idle("reset", 3);
  endtask

  task automatic test_basic();
    logic [0:19] golden = 20'b0001111001_0101001011;
    expect_frame(8'h3C, 8'hA5, -1, 8'h00, -1, "basic");
    for (int s = 0; s < 20; s++) begin
      checks++;
      if (tx_log[s*N + N/2] !== golden[s]) begin
        failures++;
        $display("FAIL basic_symbol s=%0d: got %b, want %b", s, tx_log[s*N + N/2], golden[s]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      expect_frame(8'($urandom), 8'($urandom), -1, 8'h00, -1, "random");
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_snapshot();
    expect_frame(8'hFF, 8'h00, 1, 8'h55, -1, "snapshot");
  endtask

  task automatic test_lockout();
    expect_frame(8'h96, 8'h0F, -1, 8'h00, 29, "lockout");
    check_idle("lockout_no_queue", 2 * FRAME);
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    A_In = 8'h01; B_In = 8'h80; Start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (Done === 1'b1) done_at.push_back(c);
      if (c > 1 && done_at.size() > 0 && done_at[$] == c - 1) begin
        checks++;
        if (Tx !== 1'b0 || Busy !== 1'b1) begin
          failures++;
          $display("FAIL held_restart c=%0d: got Tx=%b Busy=%b, want Tx=0 Busy=1", c, Tx, Busy);
        end
      end
    end
    Start = 1'b0;
    for (int c = 201; c <= 201 + FRAME + 10; c++) begin
      tick();
      if (Done === 1'b1) done_at.push_back(c);
    end
    // Accepts at cycles 1, 82, 163 while Start is held -> Done at 81, 162, 243.
    checks++;
    if (done_at.size() != 3) begin
      failures++;
      $display("FAIL held_done_count: got %0d, want 3", done_at.size());
    end
    for (int i = 1; i < done_at.size(); i++) begin
      checks++;
      if (done_at[i] - done_at[i-1] != FRAME + 1) begin
        failures++;
        $display("FAIL held_done_gap i=%0d: got %0d, want %0d",
                 i, done_at[i] - done_at[i-1], FRAME + 1);
      end
    end
    check_idle("held_after", 4);
  endtask

  task automatic test_reset_mid_frame();
    A_In = 8'hC3; B_In = 8'h5A; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (36) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_idle("reset_mid", 5);
    expect_frame(8'h7E, 8'h81, -1, 8'h00, -1, "after_reset");
  endtask

  task automatic test_reset_with_start();
    A_In = 8'hAA; B_In = 8'h55; Reset = 1'b1; Start = 1'b1;
    tick();
    Reset = 1'b0; Start = 1'b0;
    check_idle("reset_start", 2 * N);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_snapshot();
    test_lockout();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_with_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
